// File: rtl/mac_ifm_packer_pkg.sv
// Shared definitions for the MAC IFM packer slice.
//   MAC_W_ELEMENT / MAC_N_LANE / IFM_N_IN : default sizes of the MAC IFM path
//   ifm_beat_port : default-sized narrow beat coming from the line buffer
//   mac_ifm_port  : default-sized view of one full MAC IFM vector
//   packer_state_e: assembly state of the packer
//   slot_width()  : counter width helper that never returns zero
package mac_ifm_packer_pkg;

  localparam int MAC_W_ELEMENT = 8;
  localparam int MAC_N_LANE    = 64;
  localparam int IFM_N_IN      = 8;

  typedef struct packed {
    logic [IFM_N_IN*MAC_W_ELEMENT-1:0] data;
    logic [IFM_N_IN-1:0]               keep;
    logic                              last;
    logic                              accum_end;
  } ifm_beat_port;

  typedef struct packed {
    logic [MAC_N_LANE*MAC_W_ELEMENT-1:0] data;
    logic [MAC_N_LANE-1:0]               element_valid;
    logic                                inter_end;
    logic                                accum_end;
  } mac_ifm_port;

  // ST_PENDING means a closed vector is parked in the assembly buffer
  // waiting for the output register to free up.
  typedef enum logic {
    ST_ASSEMBLE = 1'b0,
    ST_PENDING  = 1'b1
  } packer_state_e;

  // A single-slot configuration still needs a one-bit counter.
  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_ifm_packer_vec_out_reg.sv
// Single-entry valid/ready output register for one MAC IFM vector.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture load_* this cycle (caller only asserts when out_free)
//   load_*          : vector data, per-lane valid and close flags to capture
//   o_valid/o_ready : downstream handshake
//   o_*             : registered vector presented to the MAC array
//   out_free        : register can accept a new vector this cycle
module mac_vec_out_reg
  import mac_ifm_packer_pkg::*;
#(
  parameter int VEC_W  = MAC_N_LANE * MAC_W_ELEMENT,
  parameter int N_LANE = MAC_N_LANE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [VEC_W-1:0]  load_data,
  input  logic [N_LANE-1:0] load_valid,
  input  logic              load_inter_end,
  input  logic              load_accum_end,
  input  logic              o_ready,
  output logic              o_valid,
  output logic [VEC_W-1:0]  o_data,
  output logic [N_LANE-1:0] o_element_valid,
  output logic              o_inter_end,
  output logic              o_accum_end,
  output logic              out_free
);

  // Free when empty or being drained this cycle, which lets a new vector
  // replace the outgoing one without a bubble.
  assign out_free = !o_valid || o_ready;

  // Load wins over drain; otherwise the contents stay put while stalled and
  // only o_valid drops once the vector has been taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid         <= 1'b0;
      o_data          <= '0;
      o_element_valid <= '0;
      o_inter_end     <= 1'b0;
      o_accum_end     <= 1'b0;
    end else if (load) begin
      o_valid         <= 1'b1;
      o_data          <= load_data;
      o_element_valid <= load_valid;
      o_inter_end     <= load_inter_end;
      o_accum_end     <= load_accum_end;
    end else if (o_ready) begin
      o_valid         <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_ifm_packer.sv
// Packs narrow IFM beats (N_IN elements) into one N_LANE-wide MAC IFM vector.
//   clk, rst          : clock, synchronous active-high reset
//   i_valid/i_ready   : input beat handshake (i_ready depends on state only)
//   i_data, i_keep    : beat elements and per-element valid
//   i_last            : close the vector after this beat (inter_end)
//   i_accum_end       : close the vector and flag accumulation end
//   o_valid/o_ready   : output vector handshake to the MAC array
//   o_data            : packed vector, lane k in bits [k*W_ELEMENT +: W_ELEMENT]
//   o_element_valid   : per-lane valid
//   o_inter_end       : vector was closed by i_last or i_accum_end
//   o_accum_end       : vector was closed by i_accum_end
module mac_ifm_packer
  import mac_ifm_packer_pkg::*;
#(
  parameter int W_ELEMENT = MAC_W_ELEMENT,
  parameter int N_LANE    = MAC_N_LANE,
  parameter int N_IN      = IFM_N_IN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [W_ELEMENT*N_IN-1:0]   i_data,
  input  logic [N_IN-1:0]             i_keep,
  input  logic                        i_last,
  input  logic                        i_accum_end,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [W_ELEMENT*N_LANE-1:0] o_data,
  output logic [N_LANE-1:0]           o_element_valid,
  output logic                        o_inter_end,
  output logic                        o_accum_end
);

  localparam int N_SLOT = N_LANE / N_IN;
  localparam int BEAT_W = W_ELEMENT * N_IN;
  localparam int VEC_W  = W_ELEMENT * N_LANE;
  localparam int SLOT_W = slot_width(N_SLOT);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOT - 1);

  if (N_LANE % N_IN != 0) begin : g_bad_cfg
    $error("mac_ifm_packer: N_LANE must be a multiple of N_IN");
  end

  packer_state_e     state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [VEC_W-1:0]  asm_data_q, asm_data_d;
  logic [N_LANE-1:0] asm_valid_q, asm_valid_d;
  logic              asm_inter_q, asm_inter_d;
  logic              asm_accum_q, asm_accum_d;

  logic [BEAT_W-1:0] masked_beat;
  logic [VEC_W-1:0]  merged_data;
  logic [N_LANE-1:0] merged_valid;
  logic              accept;
  logic              close;
  logic              out_free;
  logic              load;
  logic [VEC_W-1:0]  load_data;
  logic [N_LANE-1:0] load_valid;
  logic              load_inter_end;
  logic              load_accum_end;

  // While a closed vector is parked, no new beat may overwrite the buffer.
  assign i_ready = (state_q == ST_ASSEMBLE);
  assign accept  = i_valid && i_ready;
  assign close   = accept && ((slot_q == LAST_SLOT) || i_last || i_accum_end);

  // Unkept elements are forced to zero so the MAC never sees stale data.
  always_comb begin
    masked_beat = '0;
    for (int j = 0; j < N_IN; j++) begin
      masked_beat[j*W_ELEMENT +: W_ELEMENT] =
        i_keep[j] ? i_data[j*W_ELEMENT +: W_ELEMENT] : '0;
    end
  end

  // Assembly buffer with the current beat dropped into its slot; this is
  // both the next buffer contents and the vector handed over on close.
  always_comb begin
    merged_data  = asm_data_q;
    merged_valid = asm_valid_q;
    for (int s = 0; s < N_SLOT; s++) begin
      if (slot_q == SLOT_W'(s)) begin
        merged_data[s*BEAT_W +: BEAT_W] = masked_beat;
        merged_valid[s*N_IN +: N_IN]    = i_keep;
      end
    end
  end

  // Next-state and transfer control. A closing vector goes straight to the
  // output register when it is free, otherwise it is parked in the assembly
  // buffer and input stalls until the parked vector has moved on.
  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    asm_data_d     = asm_data_q;
    asm_valid_d    = asm_valid_q;
    asm_inter_d    = asm_inter_q;
    asm_accum_d    = asm_accum_q;
    load           = 1'b0;
    load_data      = merged_data;
    load_valid     = merged_valid;
    load_inter_end = i_last || i_accum_end;
    load_accum_end = i_accum_end;

    case (state_q)
      ST_ASSEMBLE: begin
        if (close) begin
          slot_d = '0;
          if (out_free) begin
            load        = 1'b1;
            asm_data_d  = '0;
            asm_valid_d = '0;
            asm_inter_d = 1'b0;
            asm_accum_d = 1'b0;
          end else begin
            state_d     = ST_PENDING;
            asm_data_d  = merged_data;
            asm_valid_d = merged_valid;
            asm_inter_d = i_last || i_accum_end;
            asm_accum_d = i_accum_end;
          end
        end else if (accept) begin
          slot_d      = slot_q + SLOT_W'(1);
          asm_data_d  = merged_data;
          asm_valid_d = merged_valid;
        end
      end

      ST_PENDING: begin
        load_data      = asm_data_q;
        load_valid     = asm_valid_q;
        load_inter_end = asm_inter_q;
        load_accum_end = asm_accum_q;
        if (out_free) begin
          load        = 1'b1;
          state_d     = ST_ASSEMBLE;
          slot_d      = '0;
          asm_data_d  = '0;
          asm_valid_d = '0;
          asm_inter_d = 1'b0;
          asm_accum_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_ASSEMBLE;
      end
    endcase
  end

  // State register; reset throws away any partial or parked vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ASSEMBLE;
      slot_q      <= '0;
      asm_data_q  <= '0;
      asm_valid_q <= '0;
      asm_inter_q <= 1'b0;
      asm_accum_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      asm_data_q  <= asm_data_d;
      asm_valid_q <= asm_valid_d;
      asm_inter_q <= asm_inter_d;
      asm_accum_q <= asm_accum_d;
    end
  end

  mac_vec_out_reg #(
    .VEC_W  (VEC_W),
    .N_LANE (N_LANE)
  ) u_out_reg (
    .clk             (clk),
    .rst             (rst),
    .load            (load),
    .load_data       (load_data),
    .load_valid      (load_valid),
    .load_inter_end  (load_inter_end),
    .load_accum_end  (load_accum_end),
    .o_ready         (o_ready),
    .o_valid         (o_valid),
    .o_data          (o_data),
    .o_element_valid (o_element_valid),
    .o_inter_end     (o_inter_end),
    .o_accum_end     (o_accum_end),
    .out_free        (out_free)
  );

endmodule

// File: tb/tb_mac_ifm_packer.sv
// Self-checking bench for mac_ifm_packer with default sizing (64 lanes, 8 per beat).
// A behavioural model turns every accepted beat into lane writes and queues
// each closed vector; the DUT output stream must match that queue in order.
module tb_mac_ifm_packer;

  localparam int W      = 8;
  localparam int NL     = 64;
  localparam int NI     = 8;
  localparam int NS     = NL / NI;
  localparam int BEAT_W = W * NI;
  localparam int VEC_W  = W * NL;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_ready;
  logic [BEAT_W-1:0] i_data = '0;
  logic [NI-1:0]     i_keep = '0;
  logic              i_last = 1'b0;
  logic              i_accum_end = 1'b0;
  logic              o_valid;
  logic              o_ready = 1'b0;
  logic [VEC_W-1:0]  o_data;
  logic [NL-1:0]     o_element_valid;
  logic              o_inter_end;
  logic              o_accum_end;

  mac_ifm_packer #(.W_ELEMENT(W), .N_LANE(NL), .N_IN(NI)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .i_ready         (i_ready),
    .i_data          (i_data),
    .i_keep          (i_keep),
    .i_last          (i_last),
    .i_accum_end     (i_accum_end),
    .o_valid         (o_valid),
    .o_ready         (o_ready),
    .o_data          (o_data),
    .o_element_valid (o_element_valid),
    .o_inter_end     (o_inter_end),
    .o_accum_end     (o_accum_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VEC_W-1:0] data;
    logic [NL-1:0]    valid;
    logic             inter;
    logic             accum;
  } vec_t;

  typedef struct {
    logic              iv;
    logic [BEAT_W-1:0] data;
    logic [NI-1:0]     keep;
    logic              last;
    logic              accum;
    logic              ordy;
    logic              chk;
    logic              exp_ovalid;
    logic              exp_iready;
  } step_t;

  int n_vec  = 0;
  int n_miss = 0;

  vec_t exp_q[$];
  vec_t out_log[$];
  logic [VEC_W-1:0] cur_data;
  logic [NL-1:0]    cur_valid;
  int               cur_cnt;

  step_t tbl[24];

  // Watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input logic [VEC_W-1:0] act,
                          input logic [VEC_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] beatData(input int base);
    logic [BEAT_W-1:0] d;
    for (int j = 0; j < NI; j++) d[j*W +: W] = W'(base + j);
    return d;
  endfunction

  function automatic step_t mkStep(input logic iv, input logic [BEAT_W-1:0] d,
                                   input logic [NI-1:0] k, input logic l,
                                   input logic a, input logic ordy,
                                   input logic chk, input logic eov,
                                   input logic eir);
    step_t s;
    s.iv = iv; s.data = d; s.keep = k; s.last = l; s.accum = a;
    s.ordy = ordy; s.chk = chk; s.exp_ovalid = eov; s.exp_iready = eir;
    return s;
  endfunction

  function automatic void modelClear();
    exp_q.delete();
    cur_data  = '0;
    cur_valid = '0;
    cur_cnt   = 0;
  endfunction

  // Reference: beat number n within the vector owns lanes n*NI .. n*NI+NI-1.
  function automatic void modelAccept(input logic [BEAT_W-1:0] d, input logic [NI-1:0] k,
                                      input logic l, input logic a);
    vec_t v;
    for (int j = 0; j < NI; j++) begin
      int lane;
      lane = cur_cnt * NI + j;
      cur_valid[lane]        = k[j];
      cur_data[lane*W +: W]  = k[j] ? d[j*W +: W] : '0;
    end
    cur_cnt++;
    if (cur_cnt == NS || l || a) begin
      v.data = cur_data; v.valid = cur_valid; v.inter = l | a; v.accum = a;
      exp_q.push_back(v);
      cur_data = '0; cur_valid = '0; cur_cnt = 0;
    end
  endfunction

  // Output holds a vector whenever one is closed but not yet taken; input
  // stalls only when two closed vectors are outstanding.
  task automatic checkOutput(input logic ordy);
    vec_t e, got;
    checkVal("o_valid", o_valid, exp_q.size() > 0);
    checkVal("i_ready", i_ready, exp_q.size() < 2);
    if (o_valid && ordy) begin
      got.data = o_data; got.valid = o_element_valid;
      got.inter = o_inter_end; got.accum = o_accum_end;
      out_log.push_back(got);
      if (exp_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("[TB] FAIL spurious_output: got vector with valid %0h expected none", o_element_valid);
      end else begin
        e = exp_q.pop_front();
        checkVal("o_data", o_data, e.data);
        checkVal("o_element_valid", o_element_valid, e.valid);
        checkVal("o_inter_end", o_inter_end, e.inter);
        checkVal("o_accum_end", o_accum_end, e.accum);
      end
    end
  endtask

  task automatic applyStimulus(input step_t s);
    @(negedge clk);
    if (s.chk) begin
      checkVal("step_o_valid", o_valid, s.exp_ovalid);
      checkVal("step_i_ready", i_ready, s.exp_iready);
    end
    checkOutput(s.ordy);
    i_valid = s.iv; i_data = s.data; i_keep = s.keep;
    i_last = s.last; i_accum_end = s.accum; o_ready = s.ordy;
    if (s.iv && i_ready) modelAccept(s.data, s.keep, s.last, s.accum);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; i_last = 1'b0; i_accum_end = 1'b0;
    modelClear();
    @(negedge clk);
    checkVal("rst_o_valid", o_valid, 1'b0);
    checkVal("rst_i_ready", i_ready, 1'b1);
    checkVal("rst_o_data", o_data, '0);
    checkVal("rst_o_element_valid", o_element_valid, '0);
    checkVal("rst_o_inter_end", o_inter_end, 1'b0);
    checkVal("rst_o_accum_end", o_accum_end, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [VEC_W-1:0] ramp;
    logic [VEC_W-1:0] snap;
    logic [NL-1:0]    vsnap;
    modelClear();

    // Table: full vector, partial with last, zero-keep beat, accum_end without last.
    for (int b = 0; b < 8; b++)
      tbl[b] = mkStep(1, beatData(b*8), 8'hFF, 0, 0, 1, 1, 0, 1);
    tbl[8]  = mkStep(0, '0, '0, 0, 0, 1, 1, 1, 1);
    tbl[9]  = mkStep(0, '0, '0, 0, 0, 1, 1, 0, 1);
    tbl[10] = mkStep(1, beatData(101), 8'hFF, 0, 0, 1, 1, 0, 1);
    tbl[11] = mkStep(1, beatData(111), 8'hFF, 0, 0, 1, 1, 0, 1);
    tbl[12] = mkStep(1, beatData(121), 8'h0F, 1, 0, 1, 1, 0, 1);
    tbl[13] = mkStep(0, '0, '0, 0, 0, 1, 1, 1, 1);
    tbl[14] = mkStep(0, '0, '0, 0, 0, 1, 1, 0, 1);
    tbl[15] = mkStep(1, beatData(131), 8'hFF, 0, 0, 1, 1, 0, 1);
    tbl[16] = mkStep(1, beatData(141), 8'h00, 0, 0, 1, 1, 0, 1);
    tbl[17] = mkStep(1, beatData(151), 8'hFF, 1, 0, 1, 1, 0, 1);
    tbl[18] = mkStep(0, '0, '0, 0, 0, 1, 1, 1, 1);
    tbl[19] = mkStep(0, '0, '0, 0, 0, 1, 1, 0, 1);
    tbl[20] = mkStep(1, beatData(161), 8'hFF, 0, 0, 1, 1, 0, 1);
    tbl[21] = mkStep(1, beatData(171), 8'hFF, 0, 1, 1, 1, 0, 1);
    tbl[22] = mkStep(0, '0, '0, 0, 0, 1, 1, 1, 1);
    tbl[23] = mkStep(0, '0, '0, 0, 0, 1, 1, 0, 1);

    doReset();
    out_log.delete();
    for (int i = 0; i < 24; i++) applyStimulus(tbl[i]);

    for (int k = 0; k < NL; k++) ramp[k*W +: W] = W'(k);
    checkVal("tbl_out_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      checkVal("full_data_ramp", out_log[0].data, ramp);
      checkVal("full_valid", out_log[0].valid, {NL{1'b1}});
      checkVal("full_inter", out_log[0].inter, 1'b0);
      checkVal("full_accum", out_log[0].accum, 1'b0);
      snap = out_log[1].data;
      checkVal("partial_valid", out_log[1].valid, 64'h00000000000FFFFF);
      checkVal("partial_upper_zero", snap[VEC_W-1:160], '0);
      checkVal("partial_inter", out_log[1].inter, 1'b1);
      checkVal("partial_accum", out_log[1].accum, 1'b0);
      snap = out_log[2].data; vsnap = out_log[2].valid;
      checkVal("zerokeep_valid_8_15", vsnap[15:8], 8'h00);
      checkVal("zerokeep_data_8_15", snap[127:64], '0);
      checkVal("zerokeep_valid_16_23", vsnap[23:16], 8'hFF);
      checkVal("accum_valid", out_log[3].valid, 64'h000000000000FFFF);
      checkVal("accum_inter", out_log[3].inter, 1'b1);
      checkVal("accum_accum", out_log[3].accum, 1'b1);
    end

    // Backpressure: two full vectors with o_ready low, then drain.
    out_log.delete();
    for (int b = 0; b < 16; b++)
      applyStimulus(mkStep(1, beatData(b*8+3), 8'hFF, 0, 0, 0, 1, b >= 8, 1));
    applyStimulus(mkStep(1, beatData(200), 8'hFF, 0, 0, 0, 1, 1, 0));
    applyStimulus(mkStep(1, beatData(210), 8'hFF, 0, 0, 0, 1, 1, 0));
    applyStimulus(mkStep(0, '0, '0, 0, 0, 1, 1, 1, 0));
    applyStimulus(mkStep(0, '0, '0, 0, 0, 1, 1, 1, 1));
    applyStimulus(mkStep(0, '0, '0, 0, 0, 1, 1, 0, 1));
    checkVal("bp_out_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      snap = out_log[0].data;
      checkVal("bp_first_lane0", snap[7:0], 8'd3);
      snap = out_log[1].data;
      checkVal("bp_second_lane0", snap[7:0], 8'd67);
    end

    // Reset in the middle of assembly discards the partial vector.
    out_log.delete();
    for (int b = 0; b < 4; b++)
      applyStimulus(mkStep(1, beatData(90+b*8), 8'hFF, 0, 0, 1, 1, 0, 1));
    doReset();
    for (int b = 0; b < 8; b++)
      applyStimulus(mkStep(1, beatData(50+b*8), 8'hFF, 0, 0, 1, 1, 0, 1));
    applyStimulus(mkStep(0, '0, '0, 0, 0, 1, 1, 1, 1));
    applyStimulus(mkStep(0, '0, '0, 0, 0, 1, 1, 0, 1));
    checkVal("rstmid_out_count", out_log.size(), 1);
    if (out_log.size() == 1) begin
      snap = out_log[0].data;
      checkVal("rstmid_lane0", snap[7:0], 8'd50);
      checkVal("rstmid_valid", out_log[0].valid, {NL{1'b1}});
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [BEAT_W-1:0] d;
      d = {$urandom, $urandom};
      applyStimulus(mkStep($urandom_range(0, 3) != 0, d, NI'($urandom),
                           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                           $urandom_range(0, 9) < 7, 0, 0, 0));
    end
    for (int c = 0; c < 4; c++) applyStimulus(mkStep(0, '0, '0, 0, 0, 1, 0, 0, 0));
    checkVal("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mac_ifm_packer.md
Name: mac_ifm_packer

Overview:
- Assembles narrow input-feature-map beats of N_IN elements into one N_LANE-wide MAC IFM vector: data, per-element valid mask, inter_end and accum_end.
- Sits between the IFM fetch/line-buffer stage and the MAC array input port.
- Parametrised successor to the fixed 64-lane IFM port:
  - Lane count and element width are generic.
  - Partial vectors are supported via early close.
  - Includes valid/ready buffering with one output register plus one pending assembly buffer.

Parameters:
- W_ELEMENT, 8, element width in bits; equals MAC_W_ELEMENT.
- N_LANE, 64, lanes per output vector.
- N_IN, 8, elements per input beat; N_LANE % N_IN == 0 is required (elaboration-time assertion).
- N_SLOT, N_LANE/N_IN, derived; beats per full vector.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  input beat accepted when i_valid && i_ready.
- i_data  in  W_ELEMENT*N_IN  elements; element j in bits [j*W_ELEMENT +: W_ELEMENT].
- i_keep  in  N_IN  per-element valid.
- i_last  in  1  closes the current vector after this beat (inter_end).
- i_accum_end  in  1  closes the vector and marks accumulation end; implies i_last.
- o_valid  out  1  output vector valid.
- o_ready  in  1  MAC array accepts the vector when o_valid && o_ready.
- o_data  out  W_ELEMENT*N_LANE  packed vector.
- o_element_valid  out  N_LANE  per-lane valid.
- o_inter_end  out  1  vector was closed by i_last or i_accum_end.
- o_accum_end  out  1  vector was closed by i_accum_end.

Behaviour:

Reset:
- o_valid=0, i_ready=1, o_data=0, o_element_valid=0, o_inter_end=0, o_accum_end=0.
- Slot counter=0, pending=0, assembly buffer cleared.
- Reset mid-assembly or mid-backpressure discards all held data; there is no partial flush.

Assembly:
- An accepted beat writes lanes [slot*N_IN +: N_IN]. Data is masked to 0 where keep=0, and element_valid=keep.
- slot increments per accepted beat.
- A beat with keep=0 still consumes its slot.

Close condition:
- A vector closes on an accepted beat with slot==N_SLOT-1, or i_last, or i_accum_end.
- Flags:
  - close=1 with i_last|i_accum_end → inter_end=1.
  - close=1 with i_accum_end → accum_end=1.
  - Full close without i_last → both flags 0.
- Lanes beyond the last written slot stay data=0, valid=0.

Transfer on close:
- If the output register is free this cycle (!o_valid || o_ready), the vector loads into it. o_valid=1 next cycle (1-cycle latency), and assembly restarts at slot 0 with a cleared buffer.
- Otherwise pending=1 and the vector is held in the assembly buffer.

Ready:
- i_ready = !pending. This is registered-state only, with no combinational path from i_valid, i_last or o_ready.

Pending:
- Pending clears when the output frees (!o_valid || o_ready).
- On that cycle the pending vector transfers; i_ready returns to 1 the next cycle.

Output:
- The output register holds stable while o_valid && !o_ready.
- On o_ready with no new vector, o_valid drops next cycle.
- Simultaneous drain and load: the new vector replaces the old with no bubble, giving full throughput of one vector per N_SLOT beats.

Ordering: vectors leave strictly in assembly order.

Decomposition:
- Shared package (mac_pkg/tx_pkg) gains:
  - MAC_N_LANE=64
  - IFM_N_IN=8
  - a default-sized typedef ifm_beat_port with data, keep, last and accum_end
- The existing mac_ifm_port typedef stays as the default-size view; this block exposes flat ports for generic N_LANE.
- One natural sub-module: mac_vec_out_reg, a single-entry valid/ready output register carrying the vector and its flags.

Test Plan:
- Full vector: N_LANE=64, N_IN=8, o_ready=1, 8 beats with keep=0xFF and element j of beat b = b*8+j → one o_valid pulse the cycle after the 8th accept; lane k=k; o_element_valid all ones; inter_end=0; accum_end=0.
- Partial vector: 3 beats keep=0xFF, 0xFF, 0x0F with i_last on the 3rd → o_element_valid=0x00000000000FFFFF; lanes 20..63 data=0; inter_end=1; accum_end=0.
- Backpressure: o_ready=0, 16 full beats → first vector in the output register, second pending, i_ready=0 after the 16th accept. Raise o_ready → vectors 1 then 2 in order, i_ready=1 again, no data loss.
- Accum end without last: i_accum_end=1 on beat 2 → vector closes with lanes 0..15 valid, inter_end=1, accum_end=1.
- Reset mid-operation: 4 beats accepted, rst for 1 cycle, then 8 new beats → no output from the first 4; the next vector starts at lane 0 with only new data; outputs are at reset values during rst.
- Zero-keep beat: beats keep=0xFF, 0x00, 0xFF, i_last → lanes 8..15 valid=0 and data=0; lanes 16..23 valid.
